camera_frame_capture: RTL and testbench

Parametrised camera capture engine for the OV7670 path. It runs in the camera pixel-clock domain, so `clk` is driven by pclk. It assembles byte pairs into RGB565 pixels, converts them to RGB444 or 8-bit grayscale, and optionally decimates by 2^DECIM_LOG2 in both axes. It writes the result into a ping-pong frame buffer, with frame handshakes and error flags for the system control FSM and the VGA reader.

---
 rtl/camera_frame_capture.sv | 205 ++++++++++++++++++++
 tb/tb_camera_frame_capture.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_frame_capture.sv
`timescale 1ns/1ps
// OV7670 capture engine in the pclk domain: pairs bytes into RGB565, converts to
// RGB444 or 8-bit gray, decimates, and writes a ping-pong frame buffer.
module camera_frame_capture #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int DECIM_LOG2 = 1,
  parameter int DOUBLE_BUF = 1,
  parameter int ADDR_W     = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        D_data,
  input  logic              capture_en,
  input  logic              single_shot,
  input  logic              gray_mode,
  input  logic              clear_err,
  output logic [11:0]       save_data,
  output logic [ADDR_W-1:0] save_address,
  output logic              write_enable,
  output logic              frame_done,
  output logic              done_bank,
  output logic [15:0]       frame_count,
  output logic              busy,
  output logic              line_err,
  output logic              overflow
);
  localparam int FRAME_WORDS = (H_ACTIVE >> DECIM_LOG2) * (V_ACTIVE >> DECIM_LOG2);
  localparam logic [ADDR_W-1:0] FW_A = ADDR_W'(FRAME_WORDS);
  localparam logic [15:0] LINE_BYTES = 16'(2 * H_ACTIVE);
  localparam logic [15:0] V_LINES    = 16'(V_ACTIVE);
  localparam logic [15:0] DECIM_MASK = 16'((1 << DECIM_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE, SKIP} state_t;
  state_t state_reg, state_next;

  logic              vsync_reg, vsync_prev, href_reg, href_prev, capture_en_reg;
  logic [7:0]        d_reg;
  logic              vsync_rise, vsync_fall, href_fall, armed, start_frame;
  logic              shot_used_reg, bank_reg, done_bank_reg, gray_reg;
  logic [15:0]       frame_count_reg;
  logic              phase_reg;
  logic [7:0]        hi_reg;
  logic [15:0]       x_reg, y_reg, byte_cnt_reg;
  logic [15:0]       pix_reg;
  logic              pix_valid_reg;
  logic [ADDR_W-1:0] index_reg, save_address_reg;
  logic [11:0]       save_data_reg, conv_data;
  logic              write_enable_reg, line_err_reg, overflow_reg;
  logic              line_err_event, overflow_event;
  logic [7:0]        r8, g8, b8;
  logic [17:0]       y_sum;

  // Edges are taken between the registered pin copy and its previous value.
  assign vsync_rise  = vsync_reg & ~vsync_prev;
  assign vsync_fall  = ~vsync_reg & vsync_prev;
  assign href_fall   = ~href_reg & href_prev;
  assign armed       = capture_en & ~(single_shot & shot_used_reg);
  assign start_frame = (state_reg == IDLE) && vsync_fall && armed;

  assign line_err_event = (state_reg == ACTIVE) && href_fall && (byte_cnt_reg != LINE_BYTES);
  assign overflow_event = (pix_valid_reg && (index_reg >= FW_A)) ||
                          ((state_reg == DONE) && (y_reg != V_LINES));

  always_comb begin
    state_next = state_reg;
    frame_done = 1'b0;
    busy       = 1'b0;
    done_bank  = done_bank_reg;
    case (state_reg)
      IDLE:   if (vsync_fall) state_next = armed ? ACTIVE : SKIP;
      ACTIVE: begin
        busy = 1'b1;
        if (vsync_rise) state_next = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        done_bank  = bank_reg;
        state_next = IDLE;
      end
      SKIP:   if (vsync_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      vsync_reg       <= 1'b0;
      vsync_prev      <= 1'b0;
      href_reg        <= 1'b0;
      href_prev       <= 1'b0;
      d_reg           <= 8'h00;
      capture_en_reg  <= 1'b0;
      shot_used_reg   <= 1'b0;
      bank_reg        <= 1'b0;
      done_bank_reg   <= 1'b0;
      frame_count_reg <= 16'h0000;
      line_err_reg    <= 1'b0;
      overflow_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      vsync_reg      <= vsync;
      vsync_prev     <= vsync_reg;
      href_reg       <= href;
      href_prev      <= href_reg;
      d_reg          <= D_data;
      capture_en_reg <= capture_en;
      if (capture_en && !capture_en_reg)
        shot_used_reg <= 1'b0;
      else if ((state_reg == DONE) && single_shot)
        shot_used_reg <= 1'b1;
      if (state_reg == DONE) begin
        done_bank_reg   <= bank_reg;
        frame_count_reg <= frame_count_reg + 16'd1;
        if (DOUBLE_BUF != 0) bank_reg <= ~bank_reg;
      end
      // A new error in the same cycle as clear_err keeps the flag set.
      if (line_err_event)  line_err_reg <= 1'b1;
      else if (clear_err)  line_err_reg <= 1'b0;
      if (overflow_event)  overflow_reg <= 1'b1;
      else if (clear_err)  overflow_reg <= 1'b0;
    end
  end

  // Byte pairing and line/pixel position tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_reg     <= 1'b0;
      hi_reg        <= 8'h00;
      x_reg         <= 16'd0;
      y_reg         <= 16'd0;
      byte_cnt_reg  <= 16'd0;
      pix_reg       <= 16'h0000;
      pix_valid_reg <= 1'b0;
      gray_reg      <= 1'b0;
    end else begin
      pix_valid_reg <= 1'b0;
      if (start_frame) begin
        phase_reg    <= 1'b0;
        x_reg        <= 16'd0;
        y_reg        <= 16'd0;
        byte_cnt_reg <= 16'd0;
        gray_reg     <= gray_mode;
      end else if (state_reg == ACTIVE) begin
        if (href_reg) begin
          byte_cnt_reg <= byte_cnt_reg + 16'd1;
          phase_reg    <= ~phase_reg;
          if (!phase_reg) begin
            hi_reg <= d_reg;
          end else begin
            pix_reg       <= {hi_reg, d_reg};
            pix_valid_reg <= ((x_reg & DECIM_MASK) == 16'd0) && ((y_reg & DECIM_MASK) == 16'd0);
            x_reg         <= x_reg + 16'd1;
          end
        end else if (href_fall) begin
          x_reg        <= 16'd0;
          phase_reg    <= 1'b0;
          byte_cnt_reg <= 16'd0;
          y_reg        <= y_reg + 16'd1;
        end
      end
    end
  end

  always_comb begin
    r8    = {pix_reg[15:11], pix_reg[15:13]};
    g8    = {pix_reg[10:5], pix_reg[10:9]};
    b8    = {pix_reg[4:0], pix_reg[4:2]};
    y_sum = 18'd77 * 18'(r8) + 18'd150 * 18'(g8) + 18'd29 * 18'(b8);
    if (gray_reg) conv_data = {4'h0, 8'(y_sum >> 8)};
    else          conv_data = {pix_reg[15:12], pix_reg[10:7], pix_reg[4:1]};
  end

  // Write stage; the in-flight pixel still lands after the frame has ended.
  always_ff @(posedge clk) begin
    if (reset) begin
      index_reg        <= '0;
      write_enable_reg <= 1'b0;
      save_data_reg    <= 12'h000;
      save_address_reg <= '0;
    end else begin
      write_enable_reg <= 1'b0;
      save_data_reg    <= 12'h000;
      save_address_reg <= '0;
      if (start_frame) begin
        index_reg <= '0;
      end else if (pix_valid_reg && (index_reg < FW_A)) begin
        write_enable_reg <= 1'b1;
        save_data_reg    <= conv_data;
        save_address_reg <= (bank_reg ? FW_A : '0) + index_reg;
        index_reg        <= index_reg + 1'b1;
      end
    end
  end

  assign save_data    = save_data_reg;
  assign save_address = save_address_reg;
  assign write_enable = write_enable_reg;
  assign frame_count  = frame_count_reg;
  assign line_err     = line_err_reg;
  assign overflow     = overflow_reg;
endmodule

// File: tb/tb_camera_frame_capture.sv
`timescale 1ns/1ps
// Bench for camera_frame_capture: two instances (decimated and full-size) share
// one camera stimulus and are scored against a frame-level reference model.
module tb_camera_frame_capture;
  localparam int H   = 8;
  localparam int V   = 4;
  localparam int FW0 = (H >> 1) * (V >> 1);
  localparam int FW1 = H * V;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, vsync, href, capture_en, single_shot, gray_mode, clear_err;
  logic [7:0] D_data;
  logic [11:0] save_data0, save_data1;
  logic [4:0] save_address0;
  logic [5:0] save_address1;
  logic write_enable0, frame_done0, done_bank0, busy0, line_err0, overflow0;
  logic write_enable1, frame_done1, done_bank1, busy1, line_err1, overflow1;
  logic [15:0] frame_count0, frame_count1;

  camera_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM_LOG2(1), .DOUBLE_BUF(1), .ADDR_W(5)) dut_d1 (
    .clk(clk), .reset(reset), .vsync(vsync), .href(href), .D_data(D_data),
    .capture_en(capture_en), .single_shot(single_shot), .gray_mode(gray_mode), .clear_err(clear_err),
    .save_data(save_data0), .save_address(save_address0), .write_enable(write_enable0),
    .frame_done(frame_done0), .done_bank(done_bank0), .frame_count(frame_count0),
    .busy(busy0), .line_err(line_err0), .overflow(overflow0));

  camera_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM_LOG2(0), .DOUBLE_BUF(1), .ADDR_W(6)) dut_d0 (
    .clk(clk), .reset(reset), .vsync(vsync), .href(href), .D_data(D_data),
    .capture_en(capture_en), .single_shot(single_shot), .gray_mode(gray_mode), .clear_err(clear_err),
    .save_data(save_data1), .save_address(save_address1), .write_enable(write_enable1),
    .frame_done(frame_done1), .done_bank(done_bank1), .frame_count(frame_count1),
    .busy(busy1), .line_err(line_err1), .overflow(overflow1));

  typedef struct { int addr; int data; int cyc; } wr_t;
  wr_t q0[$], q1[$];
  wr_t e0, e1;
  int compared = 0, mismatched = 0;
  int cyc = 0, frame_no = 0;
  int fd_cnt0 = 0, fd_cnt1 = 0, fd_before;

  // Reference model state
  bit cap_m, gray_m, shot_used_m, bank_m, lerr_m, exp_bank;
  bit ovf_m[2];
  int idx_m[2];
  int y_m, fcnt_m, fd_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s (frame %0d): observed=%0h expected=%0h", tag, frame_no, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (write_enable0) begin
      check("we0_expected", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        check("addr0", 32'(save_address0), e0.addr);
        check("data0", 32'(save_data0), e0.data);
        check("lat0", cyc, e0.cyc);
      end
    end
    if (write_enable1) begin
      check("we1_expected", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        check("addr1", 32'(save_address1), e1.addr);
        check("data1", 32'(save_data1), e1.data);
        check("lat1", cyc, e1.cyc);
      end
    end
    if (frame_done0) fd_cnt0++;
    if (frame_done1) fd_cnt1++;
  end

  function automatic int conv(input logic [15:0] p, input bit g);
    int r5, g6, b5, r8, g8, b8;
    r5 = int'(p[15:11]);
    g6 = int'(p[10:5]);
    b5 = int'(p[4:0]);
    if (g) begin
      r8 = r5 * 8 + r5 / 4;
      g8 = g6 * 4 + g6 / 16;
      b8 = b5 * 8 + b5 / 4;
      return (77 * r8 + 150 * g8 + 29 * b8) / 256;
    end
    return (r5 / 2) * 256 + (g6 / 4) * 16 + (b5 / 2);
  endfunction

  task automatic model_reset();
    while (q0.size() != 0 && q0[$].cyc > cyc) void'(q0.pop_back());
    while (q1.size() != 0 && q1[$].cyc > cyc) void'(q1.pop_back());
    cap_m = 0; shot_used_m = 0; bank_m = 0; lerr_m = 0; exp_bank = 0;
    ovf_m[0] = 0; ovf_m[1] = 0; fcnt_m = 0; y_m = 0;
  endtask

  task automatic model_frame_start();
    cap_m = capture_en && !(single_shot && shot_used_m);
    if (cap_m) begin
      gray_m = gray_mode; y_m = 0; idx_m[0] = 0; idx_m[1] = 0;
    end
  endtask

  task automatic model_pixel(input int y, input int x, input logic [15:0] p);
    if (cap_m) begin
      if (x % 2 == 0 && y % 2 == 0) begin
        if (idx_m[0] < FW0) q0.push_back('{int'(bank_m) * FW0 + idx_m[0], conv(p, gray_m), cyc + 3});
        else ovf_m[0] = 1;
        idx_m[0]++;
      end
      if (idx_m[1] < FW1) q1.push_back('{int'(bank_m) * FW1 + idx_m[1], conv(p, gray_m), cyc + 3});
      else ovf_m[1] = 1;
      idx_m[1]++;
    end
  endtask

  task automatic model_line_end(input int nb);
    if (cap_m) begin
      if (nb != 2 * H) lerr_m = 1;
      y_m++;
    end
  endtask

  task automatic model_frame_end();
    if (cap_m) begin
      fd_exp++;
      exp_bank = bank_m;
      fcnt_m = (fcnt_m + 1) % 65536;
      if (y_m != V) begin ovf_m[0] = 1; ovf_m[1] = 1; end
      bank_m = ~bank_m;
      if (single_shot) shot_used_m = 1;
      cap_m = 0;
    end
  endtask

  task automatic set_capture(input bit v);
    if (v && !capture_en) shot_used_m = 0;
    capture_en = v;
    repeat (2) tick();
  endtask

  task automatic pulse_clear();
    clear_err = 1; tick(); clear_err = 0; tick();
    lerr_m = 0; ovf_m[0] = 0; ovf_m[1] = 0;
  endtask

  task automatic drive_frame(input int nlines, input int bad_line, input int bad_bytes,
                             input bit fixed, input logic [15:0] fval, input int rst_line);
    int nb;
    logic [15:0] p;
    p = 16'h0000;
    frame_no++;
    vsync = 1; href = 0; D_data = 8'h00;
    repeat (4) tick();
    vsync = 0; model_frame_start();
    repeat (3) tick();
    for (int l = 0; l < nlines; l++) begin
      nb = (l == bad_line) ? bad_bytes : 2 * H;
      href = 1;
      for (int b = 0; b < nb; b++) begin
        if (l == 0 && b == 0) begin
          check("busy0", busy0, cap_m);
          check("busy1", busy1, cap_m);
        end
        if (l == rst_line && b == 5) begin
          reset = 1; model_reset(); tick();
          check("rst_we0", write_enable0, 0);   check("rst_we1", write_enable1, 0);
          check("rst_fc0", frame_count0, 0);    check("rst_fc1", frame_count1, 0);
          check("rst_busy0", busy0, 0);         check("rst_busy1", busy1, 0);
          check("rst_db0", done_bank0, 0);      check("rst_ovf1", overflow1, 0);
          reset = 0;
        end
        if (b % 2 == 0) p = fixed ? fval : 16'($urandom);
        D_data = (b % 2 == 0) ? p[15:8] : p[7:0];
        if (b % 2 == 1) model_pixel(l, b / 2, p);
        tick();
      end
      href = 0; D_data = 8'h00;
      model_line_end(nb);
      repeat (4) tick();
    end
    repeat (4) tick();
    vsync = 1; model_frame_end();
    repeat (4) tick();
  endtask

  task automatic check_frame();
    check("fd_count0", fd_cnt0, fd_exp);
    check("fd_count1", fd_cnt1, fd_exp);
    check("frame_count0", frame_count0, fcnt_m);
    check("frame_count1", frame_count1, fcnt_m);
    if (fd_exp > 0) begin
      check("done_bank0", done_bank0, exp_bank);
      check("done_bank1", done_bank1, exp_bank);
    end
    check("line_err0", line_err0, lerr_m);
    check("line_err1", line_err1, lerr_m);
    check("overflow0", overflow0, ovf_m[0]);
    check("overflow1", overflow1, ovf_m[1]);
    check("missing_writes0", q0.size(), 0);
    check("missing_writes1", q1.size(), 0);
  endtask

  initial begin
    reset = 1; vsync = 1; href = 0; D_data = 8'h00;
    capture_en = 0; single_shot = 0; gray_mode = 0; clear_err = 0;
    fd_exp = 0; idx_m[0] = 0; idx_m[1] = 0; gray_m = 0;
    model_reset();
    repeat (3) tick();
    check("rst_we", write_enable0, 0);
    check("rst_data", save_data0, 0);
    check("rst_addr", save_address0, 0);
    check("rst_fd", frame_done0, 0);
    check("rst_fc", frame_count0, 0);
    check("rst_busy", busy0, 0);
    check("rst_lerr", line_err0, 0);
    check("rst_ovf", overflow0, 0);
    reset = 0; tick();

    // RGB444, fixed magenta, then gray white and black into alternating banks
    set_capture(1); gray_mode = 0;
    drive_frame(V, -1, 0, 1, 16'hF81F, -1); check_frame();
    gray_mode = 1;
    drive_frame(V, -1, 0, 1, 16'hFFFF, -1); check_frame();
    drive_frame(V, -1, 0, 1, 16'h0000, -1); check_frame();
    repeat (4) begin
      gray_mode = 1'($urandom_range(0, 1));
      drive_frame(V, -1, 0, 0, 16'h0000, -1); check_frame();
    end

    // Single-shot: one frame per capture_en rising edge
    single_shot = 1; fd_before = fd_cnt0;
    repeat (3) begin
      drive_frame(V, -1, 0, 0, 16'h0000, -1); check_frame();
    end
    check("single_shot_frames", fd_cnt0 - fd_before, 1);
    set_capture(0); set_capture(1);
    drive_frame(V, -1, 0, 0, 16'h0000, -1); check_frame();
    check("rearm_frames", fd_cnt0 - fd_before, 2);
    single_shot = 0;

    // Short line, odd byte count, short frame, and clearing of sticky flags
    drive_frame(V, 1, 14, 0, 16'h0000, -1); check_frame();
    pulse_clear(); check_frame();
    drive_frame(3, -1, 0, 0, 16'h0000, -1); check_frame();
    pulse_clear(); check_frame();
    drive_frame(V, 2, 15, 0, 16'h0000, -1); check_frame();
    pulse_clear();

    // Tall frame overruns the buffer
    drive_frame(6, -1, 0, 0, 16'h0000, -1); check_frame();
    pulse_clear(); check_frame();

    // Reset mid-line, then a clean frame into bank 0
    drive_frame(V, -1, 0, 0, 16'h0000, 1); check_frame();
    gray_mode = 0;
    drive_frame(V, -1, 0, 0, 16'h0000, -1); check_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
